// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 link (receiver and transmitter).
// Holds the default frame geometry and the receiver state encoding.
package rs232_pkg;

  localparam int RS232_DATA_BITS    = 8;
  localparam int RS232_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/rs232_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops load rst_val while reset is asserted, so an idle-high line
// does not look like a start edge straight out of reset.
module rs232_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= rst_val;
      sync_out <= rst_val;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/rs232_receiver.sv
// RS-232 receiver: idle high, start bit 0, DATA_BITS data bits LSB first,
// one stop bit 1. The line is oversampled CLKS_PER_BIT times per bit and
// each bit is sampled at mid-bit.
// Optional feature macro: RX_PARITY_EN adds an even-parity bit after the
// data bits and a parity_err strobe output.
module rs232_receiver
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = RS232_CLKS_PER_BIT,
  parameter int DATA_BITS    = RS232_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 idle,
  output logic                 busy,
`ifdef RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  // The start bit is checked halfway in; after that every sample is one
  // full bit period later, which keeps all later samples at mid-bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 data_valid_n;
  logic                 frame_err_n;
`ifdef RX_PARITY_EN
  logic                 par_bad, par_bad_n;
  logic                 parity_err_n;
`endif

  rs232_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rst_val  (1'b1),
    .async_in (rx_bit),
    .sync_out (rx_s)
  );

  assign idle = (state == IDLE);
  assign busy = (state != IDLE);

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      frame_err  <= frame_err_n;
`ifdef RX_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= parity_err_n;
`endif
    end
  end

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    sh_n         = sh;
    data_n       = data;
    data_valid_n = 1'b0;
    frame_err_n  = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};
          idx_n = idx + 1'b1;
          if (idx == IDX_LAST) begin
`ifdef RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          par_bad_n = rx_s ^ (^sh);
          state_n   = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef RX_PARITY_EN
            if (par_bad) begin
              parity_err_n = 1'b1;
            end else begin
              data_n       = sh;
              data_valid_n = 1'b1;
            end
`else
            data_n       = sh;
            data_valid_n = 1'b1;
`endif
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rs232_receiver.sv
// Self-checking bench for rs232_receiver: directed scenarios followed by
// randomized frames compared against a frame-level reference model.
// Honours RX_PARITY_EN when it is defined for the build.
module tb_rs232_receiver;

  localparam int CPB = 16;
  localparam int DB  = 8;

  typedef struct packed {
    logic [1:0] kind;   // 0 = good byte, 1 = framing error, 2 = parity error
    logic [7:0] val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_bit = 1'b1;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          idle;
  logic          busy;
  logic          frame_err;
  logic          parity_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dv_count = 0;
  int fe_count = 0;
  int pe_count = 0;
  int both_high = 0;
  int data_glitch = 0;
  int last_dv_cyc = 0;
  logic [DB-1:0] prev_data = '0;
  ev_t obs_q[$];
  ev_t exp_q[$];

  rs232_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_bit     (rx_bit),
    .data       (data),
    .data_valid (data_valid),
    .idle       (idle),
    .busy       (busy),
`ifdef RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .frame_err  (frame_err)
  );

`ifndef RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Free-running clock and a cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge and log every strobe as an event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        dv_count++;
        last_dv_cyc = cyc;
        obs_q.push_back('{kind: 2'd0, val: data});
      end
      if (frame_err) begin
        fe_count++;
        obs_q.push_back('{kind: 2'd1, val: 8'h00});
      end
      if (parity_err) begin
        pe_count++;
        obs_q.push_back('{kind: 2'd2, val: 8'h00});
      end
      if (data_valid && frame_err) both_high++;
      if (data !== prev_data && !data_valid) data_glitch++;
    end
    prev_data = data;
  end

  // Hard stop in case a scenario never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the line at a level for n clocks; always ends #1 after a posedge.
  task automatic drive_line(input logic v, input int n);
    rx_bit = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one complete frame; the parity bit is only sent in parity builds.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    drive_line(1'b0, CPB);
    for (int i = 0; i < DB; i++) drive_line(b[i], CPB);
`ifdef RX_PARITY_EN
    drive_line(par_bit, CPB);
`else
    if (par_bit === 1'bx) $display("[TB] unexpected parity argument");
`endif
    drive_line(stop_bit, CPB);
  endtask

  // Reference rule for what a frame must produce, from the framing alone.
  function automatic ev_t expected_event(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    ev_t e;
    e.val = 8'h00;
    if (!stop_bit) begin
      e.kind = 2'd1;
    end else begin
`ifdef RX_PARITY_EN
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      if (((ones + int'(par_bit)) % 2) != 0) begin
        e.kind = 2'd2;
        return e;
      end
`endif
      e.kind = 2'd0;
      e.val  = b;
    end
    return e;
  endfunction

  function automatic logic even_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return logic'(ones % 2);
  endfunction

  initial begin
    int dv0, fe0, pe0, start_cyc, lat, waited, ncmp;
    logic [7:0] b, last_good;
    logic stop_bit, par_bit;
    ev_t e;

    // Reset state
    rst_n = 1'b0;
    rx_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_data", 32'(data), 32'h0);
    check_output("rst_data_valid", 32'(data_valid), 32'h0);
    check_output("rst_idle", 32'(idle), 32'h1);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    drive_line(1'b1, 20);

    // Good frame 0xAB plus latency
    dv0 = dv_count; fe0 = fe_count;
    start_cyc = cyc;
    apply_stimulus(8'hAB, 1'b1, even_par(8'hAB));
    drive_line(1'b1, 16);
    check_output("abyte_data", 32'(data), 32'hAB);
    check_output("abyte_dv_cycles", 32'(dv_count - dv0), 32'd1);
    check_output("abyte_frame_err", 32'(fe_count - fe0), 32'd0);
    check_output("abyte_idle", 32'(idle), 32'h1);
    lat = last_dv_cyc - start_cyc;
    tests++;
    assert (lat >= 154 && lat <= 156) else begin
      fails++;
      $error("[TB] FAIL latency: observed %0d clks expected 155 +/-1", lat);
    end

    // Short glitch must be rejected
    dv0 = dv_count; fe0 = fe_count;
    drive_line(1'b0, 4);
    rx_bit = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("glitch_busy_cleared", 32'(busy), 32'h0);
    drive_line(1'b1, 16);
    check_output("glitch_no_dv", 32'(dv_count - dv0), 32'd0);
    check_output("glitch_no_ferr", 32'(fe_count - fe0), 32'd0);
    check_output("glitch_data_held", 32'(data), 32'hAB);

    // Bad stop bit followed by a long break
    dv0 = dv_count; fe0 = fe_count;
    apply_stimulus(8'h3C, 1'b0, even_par(8'h3C));
    drive_line(1'b0, 50);
    drive_line(1'b1, 32);
    check_output("ferr_count", 32'(fe_count - fe0), 32'd1);
    check_output("ferr_no_dv", 32'(dv_count - dv0), 32'd0);
    check_output("ferr_data_held", 32'(data), 32'hAB);
    check_output("ferr_idle_again", 32'(idle), 32'h1);

    // Back-to-back frames, no idle gap
    obs_q.delete();
    apply_stimulus(8'h00, 1'b1, even_par(8'h00));
    apply_stimulus(8'hFF, 1'b1, even_par(8'hFF));
    drive_line(1'b1, 32);
    check_output("b2b_event_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      check_output("b2b_first", 32'({obs_q[0].kind, obs_q[0].val}), 32'h000);
      check_output("b2b_second", 32'({obs_q[1].kind, obs_q[1].val}), 32'h0FF);
    end

    // Reset during data bit 4 of 0x55
    drive_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_line(logic'((8'h55 >> i) & 8'h1), CPB);
    drive_line(1'b1, CPB / 2);
    rst_n = 1'b0;
    #1;
    check_output("midrst_data", 32'(data), 32'h0);
    check_output("midrst_idle", 32'(idle), 32'h1);
    check_output("midrst_busy", 32'(busy), 32'h0);
    check_output("midrst_strobes", 32'({data_valid, frame_err}), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_line(1'b1, 32);
    dv0 = dv_count; fe0 = fe_count;
    apply_stimulus(8'h96, 1'b1, even_par(8'h96));
    drive_line(1'b1, 16);
    check_output("postrst_data", 32'(data), 32'h96);
    check_output("postrst_dv", 32'(dv_count - dv0), 32'd1);
    check_output("postrst_ferr", 32'(fe_count - fe0), 32'd0);

`ifdef RX_PARITY_EN
    // Parity accepted and parity rejected
    dv0 = dv_count; pe0 = pe_count;
    apply_stimulus(8'hAB, 1'b1, 1'b1);
    drive_line(1'b1, 16);
    check_output("par_ok_data", 32'(data), 32'hAB);
    check_output("par_ok_dv", 32'(dv_count - dv0), 32'd1);
    dv0 = dv_count; pe0 = pe_count;
    apply_stimulus(8'hAB, 1'b1, 1'b0);
    drive_line(1'b1, 16);
    check_output("par_bad_perr", 32'(pe_count - pe0), 32'd1);
    check_output("par_bad_no_dv", 32'(dv_count - dv0), 32'd0);
    check_output("par_bad_data", 32'(data), 32'hAB);
`else
    pe0 = pe_count;
`endif

    // Randomized frames against the frame-level model
    obs_q.delete();
    exp_q.delete();
    last_good = data;
    for (int n = 0; n < 24; n++) begin
      b        = 8'($urandom);
      stop_bit = ($urandom_range(0, 7) != 0);
      par_bit  = even_par(b) ^ ($urandom_range(0, 5) == 0);
      e = expected_event(b, stop_bit, par_bit);
      exp_q.push_back(e);
      if (e.kind == 2'd0) last_good = b;
      apply_stimulus(b, stop_bit, par_bit);
      if (!stop_bit) begin
        drive_line(1'b0, $urandom_range(0, 30));
        drive_line(1'b1, $urandom_range(16, 40));
      end else begin
        drive_line(1'b1, $urandom_range(0, 40));
      end
    end
    drive_line(1'b1, 40);
    check_output("rand_event_count", 32'(obs_q.size()), 32'(exp_q.size()));
    ncmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < ncmp; i++)
      check_output($sformatf("rand_event_%0d", i),
                   32'({obs_q[i].kind, obs_q[i].val}), 32'({exp_q[i].kind, exp_q[i].val}));
    check_output("rand_final_data", 32'(data), 32'(last_good));
    check_output("dv_and_ferr_together", 32'(both_high), 32'd0);
    check_output("data_changed_without_dv", 32'(data_glitch), 32'd0);
    check_output("final_idle", 32'(idle), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
